// File: rtl/decoder_scan.sv
// Registered one-hot decoder with enable, load strobe and auto-scan at a programmable dwell rate.
// Define DEC_ERR_EN to add the err port that flags out-of-range loads.
//
//  state | meaning
//  IDLE  | en=0: y forced low, sel_q and dwell counter frozen (loads still accepted)
//  HOLD  | en=1, scan_en=0: y decodes sel_q, no stepping
//  SCAN  | en=1, scan_en=1: dwell counter runs, sel_q steps every DWELL clocks
module decoder_scan #(
  parameter int SEL_W   = 2,
  parameter int OUTPUTS = 4,
  parameter int DWELL   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               load,
  input  logic [SEL_W-1:0]   sel,
  input  logic               scan_en,
  output logic [OUTPUTS-1:0] y,
  output logic [SEL_W-1:0]   sel_q,
  output logic               wrap
`ifdef DEC_ERR_EN
  ,
  output logic               err
`endif
);

  localparam int CNT_W = $clog2(DWELL) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(OUTPUTS - 1);
  localparam logic [SEL_W:0]   SEL_LIMIT = (SEL_W + 1)'(OUTPUTS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic drive, count;

  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [SEL_W-1:0]   sel_nxt;
  logic [OUTPUTS-1:0] y_nxt;
  logic               load_ok, step, wrap_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (en) state_nxt = scan_en ? SCAN : HOLD;
      HOLD: begin
        if (!en)         state_nxt = IDLE;
        else if (scan_en) state_nxt = SCAN;
      end
      SCAN: begin
        if (!en)          state_nxt = IDLE;
        else if (!scan_en) state_nxt = HOLD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Decoded from the state being entered so en/scan_en act on the same edge.
  always_comb begin
    drive = 1'b0;
    count = 1'b0;
    unique case (state_nxt)
      HOLD: drive = 1'b1;
      SCAN: begin
        drive = 1'b1;
        count = 1'b1;
      end
      default: begin
        drive = 1'b0;
        count = 1'b0;
      end
    endcase
  end

  // A valid load takes priority over a step falling due in the same cycle.
  always_comb begin
    load_ok  = load && ({1'b0, sel} < SEL_LIMIT);
    step     = count && (cnt == CNT_LAST) && !load_ok;
    wrap_nxt = step && (sel_q == SEL_LAST);

    sel_nxt = sel_q;
    cnt_nxt = cnt;
    if (load_ok) begin
      sel_nxt = sel;
      cnt_nxt = '0;
    end else if (step) begin
      sel_nxt = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
      cnt_nxt = '0;
    end else if (count) begin
      cnt_nxt = cnt + CNT_W'(1);
    end

    y_nxt = '0;
    for (int i = 0; i < OUTPUTS; i++) begin
      y_nxt[i] = drive && (sel_nxt == SEL_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= '0;
      cnt   <= '0;
      y     <= '0;
      wrap  <= 1'b0;
    end else begin
      sel_q <= sel_nxt;
      cnt   <= cnt_nxt;
      y     <= y_nxt;
      wrap  <= wrap_nxt;
    end
  end

`ifdef DEC_ERR_EN
  generate
    if (OUTPUTS < 2 ** SEL_W) begin : g_err
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err <= 1'b0;
        else        err <= load && !load_ok;
      end
    end else begin : g_no_err
      assign err = 1'b0;
    end
  endgenerate
`endif

endmodule
